sigmoid_inverse_sar: RTL

SIGMOID_INVERSE_SAR -- requirements
Module: sigmoid_inverse_sar

---
 rtl/sigmoid_inverse_sar.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sigmoid_inverse_sar.sv
// sigmoid_inverse_sar: inverse of an 8-bit sigmoid, found by successive approximation.
// Given h = sigmoid(z) in Q0.8, returns the largest z in Q2.6 (0..255) with F(z) <= h.
// F is a fixed forward table, F(z) = floor(256/(1+exp(-z/64))).
// The conversion takes 8 search steps and one result step.
// Ports:
//   clk    - clock; all state changes on the rising edge
//   resetn - synchronous active-low reset
//   start  - request pulse; only looked at while idle
//   h_in   - sigmoid value in Q0.8; captured when start is accepted
//   busy   - a conversion is in progress
//   valid  - one-cycle pulse when z_out/sat/err are updated
//   z_out  - result in Q2.6; held until the next result or reset
//   sat    - input above the range of F; z_out clipped to 255
//   err    - input below the range of F; z_out forced to 0
module sigmoid_inverse_sar #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [DW-1:0] h_in,
  output logic          busy,
  output logic          valid,
  output logic [DW-1:0] z_out,
  output logic          sat,
  output logic          err
);

  localparam int unsigned KW     = $clog2(DW);
  localparam int unsigned N_STEP = 123;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [DW-1:0] H_MIN = DW'(128);
  localparam logic [DW-1:0] H_MAX = DW'(251);

  // F steps from 128 up to 251; entry i is the smallest z with F(z) >= 129+i.
  localparam logic [DW-1:0] F_STEP [N_STEP] = '{
    8'd2,   8'd3,   8'd4,   8'd5,   8'd6,   8'd7,   8'd8,   8'd9,   8'd10,  8'd11,
    8'd12,  8'd13,  8'd14,  8'd15,  8'd16,  8'd17,  8'd18,  8'd19,  8'd20,  8'd21,
    8'd22,  8'd23,  8'd24,  8'd25,  8'd26,  8'd27,  8'd28,  8'd29,  8'd30,  8'd31,
    8'd32,  8'd33,  8'd34,  8'd35,  8'd36,  8'd37,
    8'd39,  8'd40,  8'd41,  8'd42,  8'd43,  8'd44,  8'd45,  8'd46,
    8'd48,  8'd49,  8'd50,  8'd51,  8'd52,  8'd53,  8'd54,
    8'd56,  8'd57,  8'd58,  8'd59,
    8'd61,  8'd62,  8'd63,  8'd64,
    8'd66,  8'd67,  8'd68,  8'd69,
    8'd71,  8'd72,
    8'd74,  8'd75,  8'd76,
    8'd78,  8'd79,
    8'd81,  8'd82,  8'd83,
    8'd85,  8'd86,
    8'd88,
    8'd90,  8'd91,
    8'd93,  8'd94,
    8'd96,
    8'd98,  8'd99,
    8'd101, 8'd103, 8'd105, 8'd107, 8'd108, 8'd110, 8'd112, 8'd114, 8'd116, 8'd118,
    8'd121, 8'd123, 8'd125, 8'd127, 8'd130, 8'd132, 8'd135, 8'd137, 8'd140, 8'd143,
    8'd146, 8'd149, 8'd152, 8'd155, 8'd158, 8'd162, 8'd166, 8'd170, 8'd174, 8'd178,
    8'd183, 8'd188, 8'd193, 8'd199, 8'd205, 8'd212, 8'd220, 8'd229, 8'd239, 8'd251
  };

  // Forward table lookup: 128 plus the number of steps at or below z.
  function automatic logic [DW-1:0] f_fwd(input logic [DW-1:0] z);
    logic [DW-1:0] f;
    f = H_MIN;
    for (int unsigned i = 0; i < N_STEP; i++) begin
      if (z >= F_STEP[i]) f = f + DW'(1);
    end
    return f;
  endfunction

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [DW-1:0] h_lat;
  logic [DW-1:0] acc;
  logic [KW-1:0] k;
  logic [DW-1:0] trial;
  logic          take;

  // Next state plus the current search trial.
  always_comb begin
    state_nxt = state;
    trial     = acc | (DW'(1) << k);
    take      = (f_fwd(trial) <= h_lat);
    case (state)
      S_IDLE:   if (start) state_nxt = S_SEARCH;
      S_SEARCH: if (k == '0) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Search datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      h_lat <= '0;
      acc   <= '0;
      k     <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
      z_out <= '0;
      sat   <= 1'b0;
      err   <= 1'b0;
    end else begin
      valid <= 1'b0;
      busy  <= (state_nxt != S_IDLE);
      case (state)
        S_IDLE: begin
          if (start) begin
            h_lat <= h_in;
            acc   <= '0;
            k     <= KW'(DW - 1);
          end
        end
        S_SEARCH: begin
          if (take) acc <= trial;
          k <= k - KW'(1);
        end
        S_DONE: begin
          valid <= 1'b1;
          // Out-of-range inputs override whatever the search settled on.
          if (h_lat < H_MIN) begin
            z_out <= '0;
            sat   <= 1'b0;
            err   <= 1'b1;
          end else if (h_lat > H_MAX) begin
            z_out <= '1;
            sat   <= 1'b1;
            err   <= 1'b0;
          end else begin
            z_out <= acc;
            sat   <= 1'b0;
            err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
